fifo_rd_drain: RTL and testbench



---
 rtl/fifo_param_pkg.sv | 6 +
 rtl/fifo_rd_drain_if.sv | 13 +
 rtl/fifo_rd_skid.sv | 54 +++++
 rtl/fifo_rd_drain.sv | 87 ++++++++
 tb/tb_fifo_rd_drain.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_param_pkg.sv
// Shared sizing constants for the synchronous FIFO and its read-side drain.
package fifo_param_pkg;
  localparam int FIFO_WIDTH         = 32;
  localparam int SKID_DEPTH_DEFAULT = 4;
  localparam int CNT_W_DEFAULT      = 16;
endpackage

// File: rtl/fifo_rd_drain_if.sv
// Valid/ready stream from the read drain to a downstream consumer that may stall.
interface fifo_rd_drain_if
  import fifo_param_pkg::*;
#(
  parameter int W = FIFO_WIDTH
) ();
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/fifo_rd_skid.sv
// Ordered circular skid buffer; absorbs words already popped from the FIFO.
module fifo_rd_skid #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic                     out_valid,
  output logic [W-1:0]             out_data,
  output logic [$clog2(DEPTH):0]   occ
);
  localparam int IDX_W = $clog2(DEPTH);

  logic [W-1:0]     mem_r [DEPTH];
  logic [IDX_W-1:0] wr_idx_r;
  logic [IDX_W-1:0] rd_idx_r;
  logic [IDX_W:0]   occ_r;

  // Storage, indices and occupancy; indices wrap by natural overflow.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_idx_r <= '0;
      rd_idx_r <= '0;
      occ_r    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_r[wr_idx_r] <= push_data;
        wr_idx_r        <= wr_idx_r + IDX_W'(1);
      end else begin
        wr_idx_r <= wr_idx_r;
      end
      if (pop) begin
        rd_idx_r <= rd_idx_r + IDX_W'(1);
      end else begin
        rd_idx_r <= rd_idx_r;
      end
      case ({push, pop})
        2'b10:   occ_r <= occ_r + (IDX_W + 1)'(1);
        2'b01:   occ_r <= occ_r - (IDX_W + 1)'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

  assign out_valid = (occ_r != (IDX_W + 1)'(0));
  assign out_data  = mem_r[rd_idx_r];
  assign occ       = occ_r;
endmodule

// File: rtl/fifo_rd_drain.sv
// Read-side controller: issues FIFO reads, hides the one-cycle read latency in
// a skid buffer, streams words downstream and keeps delivery/underrun stats.
module fifo_rd_drain #(
  parameter int FIFO_WIDTH = fifo_param_pkg::FIFO_WIDTH,
  parameter int SKID_DEPTH = fifo_param_pkg::SKID_DEPTH_DEFAULT,
  parameter int CNT_W      = fifo_param_pkg::CNT_W_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  en,
  output logic                  fifo_rd_en,
  input  logic [FIFO_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  input  logic                  fifo_rd_err,
  fifo_rd_drain_if.master       out_if,
  output logic                  idle,
  output logic [CNT_W-1:0]      pop_count,
  output logic [CNT_W-1:0]      underrun_count
);
  localparam int IDX_W = $clog2(SKID_DEPTH);

  logic                  inflight_r;
  logic [CNT_W-1:0]      pop_count_r;
  logic [CNT_W-1:0]      underrun_count_r;
  logic [IDX_W:0]        occ_s;
  logic [IDX_W:0]        level_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  skid_valid_s;
  logic [FIFO_WIDTH-1:0] skid_data_s;

  // Every in-flight read already owns a slot, so the level counts it as occupied.
  assign level_s = occ_s + {{IDX_W{1'b0}}, inflight_r};
  assign push_s  = inflight_r && !fifo_rd_err;
  assign pop_s   = skid_valid_s && out_if.out_ready;

  // Read issue: registered state and the FIFO empty flag only, never out_ready.
  always_comb begin
    fifo_rd_en = 1'b0;
    if (!RST && en && !fifo_empty && (level_s < (IDX_W + 1)'(SKID_DEPTH))) begin
      fifo_rd_en = 1'b1;
    end else begin
      fifo_rd_en = 1'b0;
    end
  end

  // In-flight tracking and saturating statistics.
  always_ff @(posedge CLK) begin
    if (RST) begin
      inflight_r       <= 1'b0;
      pop_count_r      <= '0;
      underrun_count_r <= '0;
    end else begin
      inflight_r <= fifo_rd_en;
      if (pop_s && (pop_count_r != {CNT_W{1'b1}})) begin
        pop_count_r <= pop_count_r + CNT_W'(1);
      end else begin
        pop_count_r <= pop_count_r;
      end
      if (inflight_r && fifo_rd_err && (underrun_count_r != {CNT_W{1'b1}})) begin
        underrun_count_r <= underrun_count_r + CNT_W'(1);
      end else begin
        underrun_count_r <= underrun_count_r;
      end
    end
  end

  fifo_rd_skid #(
    .W     (FIFO_WIDTH),
    .DEPTH (SKID_DEPTH)
  ) u_skid (
    .CLK       (CLK),
    .RST       (RST),
    .push      (push_s),
    .push_data (fifo_rd_data),
    .pop       (pop_s),
    .out_valid (skid_valid_s),
    .out_data  (skid_data_s),
    .occ       (occ_s)
  );

  assign out_if.out_valid = skid_valid_s;
  assign out_if.out_data  = skid_data_s;
  assign idle             = (occ_s == (IDX_W + 1)'(0)) && !inflight_r;
  assign pop_count        = pop_count_r;
  assign underrun_count   = underrun_count_r;
endmodule

// File: tb/tb_fifo_rd_drain.sv
// Bench for fifo_rd_drain: queue-based FIFO with lagging empty flag, output
// order/count reference, randomized backpressure and narrow counters.
module tb_fifo_rd_drain;
  localparam int W    = 32;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          en = 1'b0;
  logic          fifo_rd_en;
  logic [W-1:0]  fifo_rd_data = '0;
  logic          fifo_empty;
  logic          fifo_rd_err = 1'b0;
  logic          idle;
  logic [CW-1:0] pop_count;
  logic [CW-1:0] underrun_count;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  fifo_rd_drain_if #(.W(W)) bus ();

  fifo_rd_drain #(.FIFO_WIDTH(W), .SKID_DEPTH(4), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .en(en), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
    .fifo_rd_err(fifo_rd_err), .out_if(bus.master), .idle(idle),
    .pop_count(pop_count), .underrun_count(underrun_count)
  );

  // FIFO model: empty flag registered from the previous count, read data one cycle late.
  logic [W-1:0] fq[$];
  logic         empty_r = 1'b1;
  logic         force_ne = 1'b0;
  assign fifo_empty = empty_r && !force_ne;

  always @(posedge CLK) begin
    empty_r <= (fq.size() == 0);
    if (fifo_rd_en) begin
      if (fq.size() > 0) begin
        fifo_rd_data <= fq.pop_front();
        fifo_rd_err  <= 1'b0;
      end else begin
        fifo_rd_err <= 1'b1;
      end
    end else begin
      fifo_rd_err <= 1'b0;
    end
  end

  // Monitor: reads issued, error responses and delivered words.
  int           n_rd = 0;
  int           n_err = 0;
  logic [W-1:0] got_q[$];
  always @(negedge CLK) begin
    if (!RST) begin
      if (fifo_rd_en) n_rd = n_rd + 1;
      if (fifo_rd_err) n_err = n_err + 1;
      if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
    end
  end

  function automatic logic [W-1:0] got_at(input int idx);
    if (idx < got_q.size()) return got_q[idx];
    return 32'hxxxx_xxxx;
  endfunction

  function automatic int sat(input int n);
    return (n > CMAX) ? CMAX : n;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    en = 1'b0;
    bus.out_ready = 1'b0;
    force_ne = 1'b0;
    step(1);
    fq.delete();
    step(2);
    RST = 1'b0;
    step(1);
  endtask

  task automatic wait_drain(input int want, input int gb, input int budget, output bit to);
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if ((got_q.size() - gb) >= want && idle && fq.size() == 0 && fifo_empty) begin
        to = 1'b0;
        break;
      end
      step(1);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    for (int i = 0; i < 3; i++) fq.push_back(32'hA0 + 32'(i));
    en = 1'b1;
    bus.out_ready = 1'b1;
    step(3);
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b want 0", fifo_rd_en); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", bus.out_data); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %b want 1", idle); end
    checks++; if (pop_count !== 4'h0 || underrun_count !== 4'h0) begin
      errors++; $display("FAIL reset_counts got %h/%h want 0/0", pop_count, underrun_count);
    end
    do_reset();
  endtask

  task automatic test_stream();
    logic [W-1:0] exp_q[$];
    int gb, eb;
    bit to;
    do_reset();
    gb = got_q.size();
    eb = n_err;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(32'h11 + 32'(i));
      fq.push_back(32'h11 + 32'(i));
    end
    en = 1'b1;
    bus.out_ready = 1'b1;
    wait_drain(8, gb, 200, to);
    checks++; if (to) begin errors++; $display("FAIL stream_timeout got %0d words want 8", got_q.size() - gb); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (got_at(gb + i) !== exp_q[i]) begin
        errors++; $display("FAIL stream_word[%0d] got %h want %h", i, got_at(gb + i), exp_q[i]);
      end
    end
    checks++; if (got_q.size() - gb != 8) begin errors++; $display("FAIL stream_count got %0d want 8", got_q.size() - gb); end
    checks++; if (pop_count !== 4'(8)) begin errors++; $display("FAIL stream_pop got %0d want 8", pop_count); end
    checks++; if (n_err - eb > 1) begin errors++; $display("FAIL stream_stale got %0d want <=1", n_err - eb); end
    checks++; if (underrun_count !== 4'(n_err - eb)) begin
      errors++; $display("FAIL stream_underrun got %0d want %0d", underrun_count, n_err - eb);
    end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL stream_idle got %b want 1", idle); end
  endtask

  task automatic test_backpressure();
    int gb, rb, bad;
    bit to;
    do_reset();
    gb = got_q.size();
    for (int i = 0; i < 8; i++) fq.push_back(32'h11 + 32'(i));
    step(2);
    rb = n_rd;
    bad = 0;
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (bus.out_valid && bus.out_data !== 32'h11) bad++;
    end
    checks++; if (n_rd - rb != 4) begin errors++; $display("FAIL bp_reads got %0d want 4", n_rd - rb); end
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h11) begin
      errors++; $display("FAIL bp_hold got %b/%h want 1/11", bus.out_valid, bus.out_data);
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_stable got %0d changes want 0", bad); end
    bus.out_ready = 1'b1;
    wait_drain(8, gb, 200, to);
    checks++; if (to || got_q.size() - gb != 8) begin
      errors++; $display("FAIL bp_count got %0d want 8", got_q.size() - gb);
    end
    for (int i = 0; i < 8; i++) begin
      checks++; if (got_at(gb + i) !== 32'h11 + 32'(i)) begin
        errors++; $display("FAIL bp_word[%0d] got %h want %h", i, got_at(gb + i), 32'h11 + 32'(i));
      end
    end
  endtask

  task automatic test_stale_empty();
    int gb, rb, eb, seen;
    do_reset();
    gb = got_q.size();
    rb = n_rd;
    eb = n_err;
    seen = 0;
    en = 1'b1;
    bus.out_ready = 1'b1;
    step(3);
    force_ne = 1'b1;
    step(1);
    force_ne = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (bus.out_valid) seen++;
    end
    checks++; if (n_rd - rb != 1) begin errors++; $display("FAIL stale_reads got %0d want 1", n_rd - rb); end
    checks++; if (n_err - eb != 1) begin errors++; $display("FAIL stale_err got %0d want 1", n_err - eb); end
    checks++; if (seen != 0 || got_q.size() != gb) begin errors++; $display("FAIL stale_valid got %0d want 0", seen); end
    checks++; if (underrun_count !== 4'(1)) begin errors++; $display("FAIL stale_underrun got %0d want 1", underrun_count); end
  endtask

  task automatic test_en_drop();
    int gb, rb;
    logic [W-1:0] first;
    do_reset();
    gb = got_q.size();
    bus.out_ready = 1'b1;
    first = $urandom;
    fq.push_back(first);
    for (int i = 0; i < 4; i++) fq.push_back($urandom);
    step(3);
    rb = n_rd;
    en = 1'b1;
    step(1);
    en = 1'b0;
    step(10);
    checks++; if (n_rd - rb != 1) begin errors++; $display("FAIL endrop_reads got %0d want 1", n_rd - rb); end
    checks++; if (got_q.size() - gb != 1 || got_at(gb) !== first) begin
      errors++; $display("FAIL endrop_word got %0d/%h want 1/%h", got_q.size() - gb, got_at(gb), first);
    end
    checks++; if (fq.size() != 4) begin errors++; $display("FAIL endrop_fifo got %0d want 4", fq.size()); end
    checks++; if (pop_count !== 4'(1)) begin errors++; $display("FAIL endrop_pop got %0d want 1", pop_count); end
  endtask

  task automatic test_reset_mid();
    int gb, rb;
    do_reset();
    rb = n_rd;
    for (int i = 0; i < 8; i++) fq.push_back($urandom);
    en = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (n_rd - rb >= 4) break;
    end
    checks++; if (bus.out_valid !== 1'b1 || idle !== 1'b0) begin
      errors++; $display("FAIL mid_pre got valid %b idle %b want 1/0", bus.out_valid, idle);
    end
    RST = 1'b1;
    step(1);
    checks++; if (bus.out_valid !== 1'b0 || idle !== 1'b1) begin
      errors++; $display("FAIL mid_rst got valid %b idle %b want 0/1", bus.out_valid, idle);
    end
    checks++; if (pop_count !== 4'h0 || underrun_count !== 4'h0) begin
      errors++; $display("FAIL mid_counts got %h/%h want 0/0", pop_count, underrun_count);
    end
    en = 1'b0;
    fq.delete();
    step(1);
    RST = 1'b0;
    gb = got_q.size();
    bus.out_ready = 1'b1;
    step(6);
    checks++; if (got_q.size() != gb) begin errors++; $display("FAIL mid_lost got %0d words want 0", got_q.size() - gb); end
  endtask

  // Random traffic: words pushed, en and out_ready toggled, output checked in order.
  task automatic run_random(input string tag, input int nwords, input bit trickle, input int cycles);
    logic [W-1:0] exp_q[$];
    logic [W-1:0] w, pd;
    int gb, eb, pushed, viol;
    bit pv, pr, to;
    do_reset();
    gb = got_q.size();
    eb = n_err;
    pushed = 0;
    viol = 0;
    en = 1'b1;
    if (!trickle) begin
      for (int i = 0; i < nwords; i++) begin
        w = $urandom; exp_q.push_back(w); fq.push_back(w); pushed++;
      end
    end
    for (int c = 0; c < cycles; c++) begin
      if (trickle && pushed < nwords && $urandom_range(0, 1) == 1) begin
        w = $urandom; exp_q.push_back(w); fq.push_back(w); pushed++;
      end
      if (trickle) en = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      pv = bus.out_valid; pr = bus.out_ready; pd = bus.out_data;
      step(1);
      if (pv && !pr && (!bus.out_valid || bus.out_data !== pd)) viol++;
    end
    while (pushed < nwords) begin
      w = $urandom; exp_q.push_back(w); fq.push_back(w); pushed++;
    end
    en = 1'b1;
    bus.out_ready = 1'b1;
    wait_drain(nwords, gb, 400, to);
    checks++; if (to || got_q.size() - gb != nwords) begin
      errors++; $display("FAIL %s_count got %0d want %0d", tag, got_q.size() - gb, nwords);
    end
    for (int i = 0; i < nwords; i++) begin
      checks++; if (got_at(gb + i) !== exp_q[i]) begin
        errors++; $display("FAIL %s_word[%0d] got %h want %h", tag, i, got_at(gb + i), exp_q[i]);
      end
    end
    checks++; if (viol != 0) begin errors++; $display("FAIL %s_stable got %0d changes want 0", tag, viol); end
    checks++; if (pop_count !== 4'(sat(nwords))) begin
      errors++; $display("FAIL %s_pop got %0d want %0d", tag, pop_count, sat(nwords));
    end
    checks++; if (underrun_count !== 4'(sat(n_err - eb))) begin
      errors++; $display("FAIL %s_underrun got %0d want %0d", tag, underrun_count, sat(n_err - eb));
    end
  endtask

  task automatic test_saturation();
    run_random("sat", 20, 1'b0, 30);
  endtask

  task automatic test_random();
    run_random("rand", 40, 1'b1, 150);
  endtask

  initial begin
    bus.out_ready = 1'b0;
    step(2);
    test_reset();
    test_stream();
    test_backpressure();
    test_stale_empty();
    test_en_drop();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
